// File: rtl/if_id_stage_ctrl_if.sv
// if_id_stage_ctrl_if: hazard/imem inputs and IF/ID outputs of the fetch stage controller.
interface if_id_stage_ctrl_if;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_inst;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        idex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    modport master (
        output stall, flush, branch_target, imem_inst, imem_ready,
        input  pc, ifid_pc, ifid_inst, ifid_valid, idex_bubble, stall_count, flush_count
    );
    modport slave (
        input  stall, flush, branch_target, imem_inst, imem_ready,
        output pc, ifid_pc, ifid_inst, ifid_valid, idex_bubble, stall_count, flush_count
    );
endinterface

// File: rtl/if_id_stage_ctrl.sv
// if_id_stage_ctrl: PC register and IF/ID pipeline register control with flush/stall/imem-wait handling.
module if_id_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic              clk,
    input logic              rst_n,
    if_id_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, IWAIT} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, ifid_pc, ifid_pc_nx, ifid_inst, ifid_inst_nx;
    logic        ifid_valid, ifid_valid_nx;
    logic [15:0] stall_count, flush_count;
    logic        run, do_flush, do_stall;
    assign run      = state != BOOT;
    assign do_flush = run & bus.flush;
    assign do_stall = run & bus.stall & ~bus.flush;
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        ifid_pc_nx    = ifid_pc;
        ifid_inst_nx  = ifid_inst;
        ifid_valid_nx = ifid_valid;
        if (!run) begin
            state_nx = RUN;
        end else if (bus.flush) begin
            state_nx      = RUN;
            pc_nx         = bus.branch_target & ~32'h3;
            ifid_pc_nx    = '0;
            ifid_inst_nx  = NOP_INST;
            ifid_valid_nx = 1'b0;
        end else if (!bus.stall) begin
            state_nx      = bus.imem_ready ? RUN : IWAIT;
            pc_nx         = bus.imem_ready ? pc + 32'd4 : pc;
            ifid_pc_nx    = bus.imem_ready ? pc : ifid_pc;
            ifid_inst_nx  = bus.imem_ready ? bus.imem_inst : NOP_INST;
            ifid_valid_nx = bus.imem_ready;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            ifid_pc     <= '0;
            ifid_inst   <= NOP_INST;
            ifid_valid  <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            ifid_pc     <= ifid_pc_nx;
            ifid_inst   <= ifid_inst_nx;
            ifid_valid  <= ifid_valid_nx;
            stall_count <= (do_stall && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
            flush_count <= (do_flush && flush_count != 16'hFFFF) ? flush_count + 16'd1 : flush_count;
        end
    end
    assign bus.pc          = pc;
    assign bus.ifid_pc     = ifid_pc;
    assign bus.ifid_inst   = ifid_inst;
    assign bus.ifid_valid  = ifid_valid;
    assign bus.idex_bubble = run & (bus.stall | bus.flush);
    assign bus.stall_count = stall_count;
    assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// tb_if_id_stage_ctrl: directed vector table, corner sequences and randomized run against a rule-level model.
module tb_if_id_stage_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_id_stage_ctrl_if bus ();
    if_id_stage_ctrl #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;
    int checks = 0;
    int errors = 0;

    // ctl = {stall, flush, imem_ready}; vb = {ifid_valid, idex_bubble}
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] target;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] ifid_inst;
        logic [1:0]  vb;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;
    vec_t tbl[14];

    bit          m_boot;
    logic [31:0] m_pc, m_ifid_pc, m_inst;
    logic        m_valid;
    int          m_sc, m_fc;
    logic        bub_seen, bub_exp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_boot = 1; m_pc = 32'h0; m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic m_step(input logic s, input logic f, input logic r, input logic [31:0] t, input logic [31:0] i);
        if (m_boot) m_boot = 0;
        else if (f) begin
            m_pc = {t[31:2], 2'b00}; m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0;
            m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
        end else if (s) m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        else if (!r) begin
            m_inst = NOP; m_valid = 1'b0;
        end else begin
            m_ifid_pc = m_pc; m_inst = i; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".ifid_pc"}, bus.ifid_pc, m_ifid_pc);
        chk({tag, ".ifid_inst"}, bus.ifid_inst, m_inst);
        chk({tag, ".ifid_valid"}, {31'b0, bus.ifid_valid}, {31'b0, m_valid});
        chk({tag, ".stall_count"}, {16'b0, bus.stall_count}, m_sc);
        chk({tag, ".flush_count"}, {16'b0, bus.flush_count}, m_fc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"}, bus.pc, 32'h0);
        chk({tag, ".ifid_pc"}, bus.ifid_pc, 32'h0);
        chk({tag, ".ifid_inst"}, bus.ifid_inst, NOP);
        chk({tag, ".ifid_valid"}, {31'b0, bus.ifid_valid}, 32'h0);
        chk({tag, ".idex_bubble"}, {31'b0, bus.idex_bubble}, 32'h0);
        chk({tag, ".stall_count"}, {16'b0, bus.stall_count}, 32'h0);
        chk({tag, ".flush_count"}, {16'b0, bus.flush_count}, 32'h0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input bit cmp, input string tag);
        #2;
        bub_seen = bus.idex_bubble;
        bub_exp  = !m_boot && (bus.stall || bus.flush);
        if (cmp) chk({tag, ".idex_bubble"}, {31'b0, bub_seen}, {31'b0, bub_exp});
        @(posedge clk);
        #1;
        m_step(bus.stall, bus.flush, bus.imem_ready, bus.branch_target, bus.imem_inst);
        if (cmp) chk_model(tag);
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t, input logic [31:0] i);
        bus.stall = s; bus.flush = f; bus.imem_ready = r; bus.branch_target = t; bus.imem_inst = i;
    endtask

    initial begin
        logic [31:0] held_pc;
        tbl[0]  = '{3'b111, 32'h40,  32'h00100093, 32'h0,   32'h0,   NOP,          2'b00, 16'd0, 16'd0};
        tbl[1]  = '{3'b001, 32'h0,   32'h00100093, 32'h4,   32'h0,   32'h00100093, 2'b10, 16'd0, 16'd0};
        tbl[2]  = '{3'b001, 32'h0,   32'h00200113, 32'h8,   32'h4,   32'h00200113, 2'b10, 16'd0, 16'd0};
        tbl[3]  = '{3'b001, 32'h0,   32'h00300193, 32'hC,   32'h8,   32'h00300193, 2'b10, 16'd0, 16'd0};
        tbl[4]  = '{3'b101, 32'h0,   32'h00400213, 32'hC,   32'h8,   32'h00300193, 2'b11, 16'd1, 16'd0};
        tbl[5]  = '{3'b001, 32'h0,   32'h00400213, 32'h10,  32'hC,   32'h00400213, 2'b10, 16'd1, 16'd0};
        tbl[6]  = '{3'b111, 32'h103, 32'h00500293, 32'h100, 32'h0,   NOP,          2'b01, 16'd1, 16'd1};
        tbl[7]  = '{3'b000, 32'h0,   32'h00500293, 32'h100, 32'h0,   NOP,          2'b00, 16'd1, 16'd1};
        tbl[8]  = '{3'b000, 32'h0,   32'h00500293, 32'h100, 32'h0,   NOP,          2'b00, 16'd1, 16'd1};
        tbl[9]  = '{3'b000, 32'h0,   32'h00500293, 32'h100, 32'h0,   NOP,          2'b00, 16'd1, 16'd1};
        tbl[10] = '{3'b001, 32'h0,   32'h00500293, 32'h104, 32'h100, 32'h00500293, 2'b10, 16'd1, 16'd1};
        tbl[11] = '{3'b000, 32'h0,   32'h00600313, 32'h104, 32'h100, NOP,          2'b00, 16'd1, 16'd1};
        tbl[12] = '{3'b101, 32'h0,   32'h00600313, 32'h104, 32'h100, NOP,          2'b01, 16'd2, 16'd1};
        tbl[13] = '{3'b001, 32'h0,   32'h00600313, 32'h108, 32'h104, 32'h00600313, 2'b10, 16'd2, 16'd1};

        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
        #12;
        chk_reset("reset");
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].target, tbl[i].inst);
            cycle(1'b0, "vec");
            chk($sformatf("vec%0d.idex_bubble", i), {31'b0, bub_seen}, {31'b0, tbl[i].vb[0]});
            chk($sformatf("vec%0d.pc", i), bus.pc, tbl[i].pc);
            chk($sformatf("vec%0d.ifid_pc", i), bus.ifid_pc, tbl[i].ifid_pc);
            chk($sformatf("vec%0d.ifid_inst", i), bus.ifid_inst, tbl[i].ifid_inst);
            chk($sformatf("vec%0d.ifid_valid", i), {31'b0, bus.ifid_valid}, {31'b0, tbl[i].vb[1]});
            chk($sformatf("vec%0d.stall_count", i), {16'b0, bus.stall_count}, {16'b0, tbl[i].sc});
            chk($sformatf("vec%0d.flush_count", i), {16'b0, bus.flush_count}, {16'b0, tbl[i].fc});
        end

        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
        cycle(1'b1, "wrap_flush");
        chk("wrap_flush.pc", bus.pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
        cycle(1'b1, "wrap_adv");
        chk("wrap_adv.pc", bus.pc, 32'h0);
        chk("wrap_adv.ifid_pc", bus.ifid_pc, 32'hFFFF_FFFC);

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                  $urandom, $urandom);
            cycle(1'b1, "rand");
        end

        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
        held_pc = bus.pc;
        for (int i = 0; i < 70000; i++) cycle(1'b0, "sat");
        chk("sat.stall_count", {16'b0, bus.stall_count}, 32'h0000_FFFF);
        chk("sat.pc_held", bus.pc, held_pc);
        chk_model("sat");

        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        m_reset();
        @(posedge clk);
        #1;
        chk_reset("async_reset_edge");
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h00A00513);
        for (int i = 0; i < 4; i++) cycle(1'b1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_stage_ctrl.md
IF_ID_STAGE_CTRL -- requirements
Module: if_id_stage_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction word (addi x0,x0,0) injected as a bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  load-use stall request from the hazard detection unit, same-cycle combinational.
REQ-006 flush  input  1  taken branch/jump resolved in EX; redirect fetch this cycle.
REQ-007 branch_target  input  32  redirect address, valid when flush=1.
REQ-008 imem_inst  input  32  instruction read at address pc.
REQ-009 imem_ready  input  1  imem_inst valid this cycle.
REQ-010 pc  output  32  current fetch address, registered.
REQ-011 ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 ifid_inst  output  32  instruction held in IF/ID, presented to the ID stage.
REQ-013 ifid_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-014 idex_bubble  output  1  zeroes ID/EX control signals this cycle.
REQ-015 stall_count  output  16  saturating count of stall cycles.
REQ-016 flush_count  output  16  saturating count of flushes.

Function
REQ-017 FSM states: BOOT, RUN, IWAIT; encoding is internal.
REQ-018 BOOT lasts exactly one cycle after reset release: pc holds, IF/ID unchanged, next state RUN; stall and flush are ignored in BOOT.
REQ-019 Per-cycle priority in RUN/IWAIT, first match only: flush > stall > !imem_ready > advance.
REQ-020 flush: pc <= {branch_target[31:2],2'b00}; ifid_inst <= NOP_INST; ifid_valid <= 0; ifid_pc <= 0; flush_count += 1; next state RUN.
REQ-021 stall with flush=0: pc, ifid_pc, ifid_inst and ifid_valid all hold; stall_count += 1; state unchanged; imem_inst is discarded and the address is refetched.
REQ-022 imem_ready=0 with stall=0 and flush=0: pc holds; ifid_inst <= NOP_INST; ifid_valid <= 0; next state IWAIT.
REQ-023 Advance (imem_ready=1, stall=0, flush=0): ifid_pc <= pc; ifid_inst <= imem_inst; ifid_valid <= 1; pc <= pc + 4; next state RUN.
REQ-024 pc + 4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000 with no other effect.
REQ-025 idex_bubble = stall | flush, combinational, and is forced to 0 in BOOT.
REQ-026 stall_count and flush_count saturate at 16'hFFFF and never wrap.
REQ-027 stall and flush asserted together: flush takes priority and stall_count does not increment.
REQ-028 A stall held for N consecutive cycles holds IF/ID and pc for exactly N cycles; the first advance then occurs on the cycle stall deasserts, if imem_ready=1.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, ifid_pc=0, ifid_inst=NOP_INST, ifid_valid=0, stall_count=0, flush_count=0, state=BOOT; idex_bubble=0.
REQ-030 Reset asserted mid-operation (during a stall, IWAIT or flush) overrides everything immediately and asynchronously; there is no partial update on the next edge.

Verification
REQ-031 Reset release, imem_ready=1 with instructions I0,I1,I2 -> BOOT holds pc=0 for 1 cycle; then ifid_inst=I0 with ifid_pc=0, then I1 with 4, then I2 with 8; pc increments by 4 per cycle.
REQ-032 stall=1 for 1 cycle while ifid_pc=8 -> idex_bubble=1 that cycle; ifid_pc stays 8 and pc stays 12; stall_count=1; advance resumes the following cycle.
REQ-033 flush=1 with branch_target=32'h0000_0103 and stall=1 -> pc=32'h0000_0100; ifid_inst=32'h0000_0013; ifid_valid=0; flush_count=1; stall_count unchanged.
REQ-034 imem_ready=0 for 3 cycles -> 3 bubbles with ifid_valid=0 and pc held; then ifid_inst=imem_inst once imem_ready=1.
REQ-035 pc=32'hFFFF_FFFC then advance -> pc=0; ifid_pc=32'hFFFF_FFFC; stall held for 70000 cycles -> stall_count=16'hFFFF.
REQ-036 rst_n pulsed low mid-stall between clock edges -> all outputs take their reset values immediately, without waiting for a clock edge.
